axis_block_assembler: RTL
=========================

// Module: axis_block_assembler
// PURPOSE
//  AXI-Stream sink directly downstream of the stream transmitter. Packs DATA_WIDTH beats
//  into one BLOCK_WIDTH rate block (little-endian: beat 0 -> bits [DATA_WIDTH-1:0]).
//  Hands each block to the SHA3 absorb stage over a valid/ready block interface.
// PARAMETERS
//  DATA_WIDTH   64    stream beat width; multiple of 8
//  BLOCK_WIDTH  1088  rate block width (SHA3-256); multiple of DATA_WIDTH; N=BLOCK_WIDTH/DATA_WIDTH
// PORTS
//  ACLK       in   1                clock; all logic on posedge
//  ARESETn    in   1                reset, asynchronous, active-low
//  S_TVALID   in   1                beat valid
//  S_TREADY   out  1                beat accept
//  S_TDATA    in   DATA_WIDTH       beat data
//  S_TKEEP    in   DATA_WIDTH/8     byte enables; only the TLAST beat may be partial
//  S_TLAST    in   1                last beat of message
//  S_TUSER    in   2                sideband, captured from first beat of block
//  S_TID      in   1                stream id, captured from first beat of block
//  blk_valid  out  1                block available
//  blk_ready  in   1                block consumed
//  blk_data   out  BLOCK_WIDTH      assembled block
//  blk_bytes  out  $clog2(BLOCK_WIDTH/8+1)  message bytes in block
//  blk_last   out  1                final block of message
//  blk_user   out  2 / blk_id out 1 captured sideband
//  err_keep   out  1                1-cycle pulse on illegal TKEEP
// BEHAVIOUR
//  - Reset (async, ARESETn=0): S_TREADY=0, blk_valid=0, blk_data=0, blk_bytes=0, blk_last=0,
//    blk_user=0, blk_id=0, err_keep=0, word_cnt=0, state FILL. S_TREADY rises on first posedge after release.
//  - FILL: S_TREADY=1. Beat accepted when S_TVALID&&S_TREADY: bytes with TKEEP=0 written as 0x00
//    into word slot word_cnt; blk_bytes += popcount(TKEEP); word_cnt++.
//  - Block completes on accepted beat with word_cnt==N-1 or S_TLAST=1 -> HOLD next cycle
//    (blk_valid asserted 1 cycle after completing beat). Unfilled words are zero.
//  - HOLD: S_TREADY=0; blk_* outputs stable while blk_valid&&!blk_ready. On blk_ready:
//    buffer, blk_bytes, word_cnt cleared, back to FILL; S_TREADY=1 next cycle.
//    One dead cycle per block; no accept/emit overlap.
//  - blk_last=1 iff block closed by TLAST (see CONFIGURATION for exact-fill case).
//  - err_keep: accepted beat with (!TLAST && TKEEP!=all-ones) or non-contiguous TKEEP
//    (not 0..01..1 from LSB). Data still masked/counted per TKEEP.
//  - TLAST beat with TKEEP=0 legal: contributes 0 bytes.
//  - Reset mid-block: partial block discarded; next packet starts at word 0.
// CONFIGURATION
//  SHA3_RX_PAD_EN defined: SHA3 pad10*1 applied in block before HOLD:
//   byte[blk_bytes] ^= 8'h06, byte[BLOCK_WIDTH/8-1] ^= 8'h80 (same byte -> 8'h86).
//   If TLAST block has blk_bytes==BLOCK_WIDTH/8: block emitted with blk_last=0, then state PAD
//   emits extra block (byte0=8'h06, last byte=8'h80, rest 0, blk_bytes=0, blk_last=1, same id/user).
//  Undefined: no padding; blk_last=1 on TLAST block; downstream pads using blk_bytes.
// STRUCTURE
//  Package sha3_axis_pkg: state enum {FILL,HOLD,PAD}, SHA3_PAD_FIRST=8'h06, SHA3_PAD_LAST=8'h80,
//   default rate constants.
//  Sub-module axis_keep_check: combinational popcount(TKEEP) + contiguity flag.
// TESTING  (DATA_WIDTH=64, BLOCK_WIDTH=1088: N=17, 136 bytes)
//  1. 17 full beats, TDATA=index, TLAST on 17th -> one block, bits[64i+:64]=i, blk_bytes=136;
//     no PAD: blk_last=1; PAD: blk_last=0 then pad block byte0=06, byte135=80, blk_last=1.
//  2. 3 beats, last TKEEP=8'h0F+TLAST -> blk_bytes=20, bytes 20..135=0 (no PAD) /
//     byte20=06, byte135=80 (PAD).
//  3. 16 full beats + TKEEP=8'h7F+TLAST (PAD) -> blk_bytes=135, byte135=8'h86.
//  4. blk_ready=0 for 10 cycles in HOLD -> blk_valid/blk_data stable, S_TREADY=0, no beat lost.
//  5. TKEEP=8'h0F without TLAST -> err_keep high exactly 1 cycle; TKEEP=8'h05+TLAST -> err_keep.
//  6. ARESETn low after 5 beats -> outputs reset asynchronously; no blk_valid;
//     next 17-beat packet lands at word 0.

Source files
------------

// File: rtl/sha3_axis_pkg.sv
// Shared types and constants for the AXI-Stream to SHA3 rate-block assembler.
package sha3_axis_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        PAD  = 2'd2
    } state_e;

    localparam logic [7:0] SHA3_PAD_FIRST = 8'h06;
    localparam logic [7:0] SHA3_PAD_LAST  = 8'h80;

    localparam int SHA3_DEFAULT_DATA_WIDTH = 64;
    localparam int SHA3_256_RATE_BITS      = 1088;

endpackage

// File: rtl/axis_keep_check.sv
// Combinational TKEEP analysis: byte count and "ones packed from the LSB" flag.
module axis_keep_check #(
    parameter int KEEP_W = 8,
    parameter int CNT_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  popcnt,
    output logic              contig
);

    logic [KEEP_W-1:0] keep_inc;

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            popcnt = popcnt + CNT_W'(keep[i]);
        end
    end

    // A 0..01..1 pattern plus one is a power of two, so it shares no set bit with itself.
    assign keep_inc = keep + KEEP_W'(1);
    assign contig   = ((keep & keep_inc) == '0);

endmodule

// File: rtl/axis_block_assembler.sv
// Packs AXI-Stream beats into SHA3 rate blocks for the absorb stage.
// Define SHA3_RX_PAD_EN to apply pad10*1 in-line (with an extra PAD block on exact fill).
module axis_block_assembler
    import sha3_axis_pkg::*;
#(
    parameter int DATA_WIDTH  = SHA3_DEFAULT_DATA_WIDTH,
    parameter int BLOCK_WIDTH = SHA3_256_RATE_BITS
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETn,
    input  logic                                 S_TVALID,
    output logic                                 S_TREADY,
    input  logic [DATA_WIDTH-1:0]                S_TDATA,
    input  logic [DATA_WIDTH/8-1:0]              S_TKEEP,
    input  logic                                 S_TLAST,
    input  logic [1:0]                           S_TUSER,
    input  logic                                 S_TID,
    output logic                                 blk_valid,
    input  logic                                 blk_ready,
    output logic [BLOCK_WIDTH-1:0]               blk_data,
    output logic [$clog2(BLOCK_WIDTH/8+1)-1:0]   blk_bytes,
    output logic                                 blk_last,
    output logic [1:0]                           blk_user,
    output logic                                 blk_id,
    output logic                                 err_keep
);

    localparam int KEEP_W      = DATA_WIDTH / 8;
    localparam int N_WORDS     = BLOCK_WIDTH / DATA_WIDTH;
    localparam int BLOCK_BYTES = BLOCK_WIDTH / 8;
    localparam int BYTES_W     = $clog2(BLOCK_BYTES + 1);
    localparam int WCNT_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int KCNT_W      = $clog2(KEEP_W + 1);

    state_e                   state_q, state_d;
    logic                     tready_q, tready_d;
    logic [BLOCK_WIDTH-1:0]   data_q, data_d;
    logic [BYTES_W-1:0]       bytes_q, bytes_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
    logic                     last_q, last_d;
    logic [1:0]               user_q, user_d;
    logic                     id_q, id_d;
    logic                     err_q, err_d;
    logic                     pad_pend_q, pad_pend_d;

    logic [KCNT_W-1:0]        keep_cnt;
    logic                     keep_contig;
    logic [DATA_WIDTH-1:0]    keep_mask;
    logic [DATA_WIDTH-1:0]    beat_masked;
    logic [BYTES_W-1:0]       bytes_sum;
    logic                     accept;
    logic                     complete;

    axis_keep_check #(
        .KEEP_W (KEEP_W),
        .CNT_W  (KCNT_W)
    ) u_keep_check (
        .keep   (S_TKEEP),
        .popcnt (keep_cnt),
        .contig (keep_contig)
    );

    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_keep_mask
        assign keep_mask[gi*8 +: 8] = {8{S_TKEEP[gi]}};
    end

    assign beat_masked = S_TDATA & keep_mask;
    assign bytes_sum   = bytes_q + BYTES_W'(keep_cnt);
    assign accept      = S_TVALID && tready_q;
    assign complete    = accept && (S_TLAST || (wcnt_q == WCNT_W'(N_WORDS - 1)));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= FILL;
            tready_q   <= 1'b0;
            data_q     <= '0;
            bytes_q    <= '0;
            wcnt_q     <= '0;
            last_q     <= 1'b0;
            user_q     <= '0;
            id_q       <= 1'b0;
            err_q      <= 1'b0;
            pad_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tready_q   <= tready_d;
            data_q     <= data_d;
            bytes_q    <= bytes_d;
            wcnt_q     <= wcnt_d;
            last_q     <= last_d;
            user_q     <= user_d;
            id_q       <= id_d;
            err_q      <= err_d;
            pad_pend_q <= pad_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (complete)  state_d = HOLD;
            HOLD:    if (blk_ready) state_d = pad_pend_q ? PAD : FILL;
            PAD:     if (blk_ready) state_d = FILL;
            default:                state_d = FILL;
        endcase
    end

    // TREADY is registered so it stays low through reset and rises one edge after release.
    always_comb begin
        tready_d  = (state_d == FILL);
        blk_valid = (state_q == HOLD) || (state_q == PAD);
    end

    always_comb begin
        data_d     = data_q;
        bytes_d    = bytes_q;
        wcnt_d     = wcnt_q;
        last_d     = last_q;
        user_d     = user_q;
        id_d       = id_q;
        err_d      = 1'b0;
        pad_pend_d = pad_pend_q;

        if (accept) begin
            data_d[wcnt_q*DATA_WIDTH +: DATA_WIDTH] = beat_masked;
            bytes_d = bytes_sum;
            wcnt_d  = wcnt_q + WCNT_W'(1);
            err_d   = (!S_TLAST && (S_TKEEP != '1)) || !keep_contig;
            if (wcnt_q == '0) begin
                user_d = S_TUSER;
                id_d   = S_TID;
            end
            if (complete) begin
`ifdef SHA3_RX_PAD_EN
                if (S_TLAST && (bytes_sum == BYTES_W'(BLOCK_BYTES))) begin
                    // No room for the padding bytes: defer them to a dedicated block.
                    last_d     = 1'b0;
                    pad_pend_d = 1'b1;
                end else if (S_TLAST) begin
                    data_d[{bytes_sum, 3'b000} +: 8] = data_d[{bytes_sum, 3'b000} +: 8] ^ SHA3_PAD_FIRST;
                    data_d[BLOCK_WIDTH-8 +: 8]       = data_d[BLOCK_WIDTH-8 +: 8] ^ SHA3_PAD_LAST;
                    last_d = 1'b1;
                end else begin
                    last_d = 1'b0;
                end
`else
                last_d = S_TLAST;
`endif
            end
        end

        if (blk_valid && blk_ready) begin
            data_d  = '0;
            bytes_d = '0;
            wcnt_d  = '0;
            last_d  = 1'b0;
            if ((state_q == HOLD) && pad_pend_q) begin
                data_d[7:0]                = SHA3_PAD_FIRST;
                data_d[BLOCK_WIDTH-8 +: 8] = data_d[BLOCK_WIDTH-8 +: 8] ^ SHA3_PAD_LAST;
                last_d     = 1'b1;
                pad_pend_d = 1'b0;
            end
        end
    end

    assign S_TREADY  = tready_q;
    assign blk_data  = data_q;
    assign blk_bytes = bytes_q;
    assign blk_last  = last_q;
    assign blk_user  = user_q;
    assign blk_id    = id_q;
    assign err_keep  = err_q;

endmodule
